// File: rtl/if_id_buffer.sv
// Elastic IF/ID instruction buffer: a DEPTH-entry FIFO of {PC+4, instruction} with flush.
// Optional macro IF_ID_STALL_STATS_EN adds a saturating decode-stall counter (StallCycles).
module if_id_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_W-1:0]        InInstr,
  input  logic [PC_W-1:0]          InPC,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_W-1:0]        OutInstr,
  output logic [PC_W-1:0]          OutPC,
  output logic [15:0]              OutImm16,
`ifdef IF_ID_STALL_STATS_EN
  output logic [15:0]              StallCycles,
`endif
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;

  // Handshake flags depend only on registered occupancy.
  assign InReady  = (count_q < CntW'(DEPTH));
  assign OutValid = (count_q != '0);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;

  assign OutInstr = instr_q[rd_ptr_q];
  assign OutPC    = pc_q[rd_ptr_q];
  assign OutImm16 = OutInstr[15:0];
  assign Count    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps the pointers.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is only cleared by reset; a flush leaves stale contents behind.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push && !Flush) begin
      instr_q[wr_ptr_q] <= InInstr;
      pc_q[wr_ptr_q]    <= InPC;
    end
  end

`ifdef IF_ID_STALL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_q <= '0;
    end else if (Flush) begin
      stall_q <= '0;
    end else if (OutValid && !OutReady && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign StallCycles = stall_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer (DEPTH=2): table-driven vectors plus directed sequences.
module tb_if_id_buffer;

  logic        Clk;
  logic        Reset_n;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] InInstr;
  logic [31:0] InPC;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [15:0] OutImm16;
  logic [1:0]  Count;
`ifdef IF_ID_STALL_STATS_EN
  logic [15:0] StallCycles;
`endif

  int n_checks;
  int n_fail;

  if_id_buffer #(
    .DEPTH  (2),
    .DATA_W (32),
    .PC_W   (32)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .InInstr  (InInstr),
    .InPC     (InPC),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutInstr (OutInstr),
    .OutPC    (OutPC),
    .OutImm16 (OutImm16),
`ifdef IF_ID_STALL_STATS_EN
    .StallCycles (StallCycles),
`endif
    .Count    (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        exp_valid;
    logic        exp_in_ready;
    logic [1:0]  exp_count;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    InValid  = v;
    InInstr  = ins;
    InPC     = pc;
    OutReady = rdy;
    Flush    = fl;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic ir, input logic [1:0] c);
    chk({tag, ".valid"}, 64'(OutValid), 64'(v));
    chk({tag, ".in_ready"}, 64'(InReady), 64'(ir));
    chk({tag, ".count"}, 64'(Count), 64'(c));
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] w;
    w = ins;
    chk({tag, ".instr"}, 64'(OutInstr), 64'(ins));
    chk({tag, ".pc"}, 64'(OutPC), 64'(pc));
    chk({tag, ".imm16"}, 64'(OutImm16), 64'(w[15:0]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // {in_valid, instr, pc, out_ready, exp_valid, exp_in_ready, exp_count, exp_instr, exp_pc}
    vecs[0] = '{1'b1, 32'h2008000A, 32'h4,  1'b1, 1'b1, 1'b1, 2'd1, 32'h2008000A, 32'h4};
    vecs[1] = '{1'b1, 32'h8C09FFFC, 32'h8,  1'b1, 1'b1, 1'b1, 2'd1, 32'h8C09FFFC, 32'h8};
    vecs[2] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h2008000A, 32'h4};
    vecs[3] = '{1'b1, 32'h00000111, 32'hC,  1'b0, 1'b1, 1'b1, 2'd1, 32'h00000111, 32'hC};
    vecs[4] = '{1'b1, 32'h00000222, 32'h10, 1'b0, 1'b1, 1'b0, 2'd2, 32'h00000111, 32'hC};
    vecs[5] = '{1'b1, 32'h00000333, 32'h14, 1'b0, 1'b1, 1'b0, 2'd2, 32'h00000111, 32'hC};
    vecs[6] = '{1'b1, 32'h00000333, 32'h14, 1'b1, 1'b1, 1'b1, 2'd1, 32'h00000222, 32'h10};
    vecs[7] = '{1'b1, 32'h00000333, 32'h14, 1'b0, 1'b1, 1'b0, 2'd2, 32'h00000222, 32'h10};
    vecs[8] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 32'h00000333, 32'h14};
    vecs[9] = '{1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h00000222, 32'h10};

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    Reset_n = 1'b0;
    #12;
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk_head("reset", 32'h0, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;

    // Pass-through, fill, back-pressure and drain.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_instr, vecs[i].in_pc, vecs[i].out_ready, 1'b0);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_in_ready,
                vecs[i].exp_count);
      chk_head($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc);
    end

    // Simultaneous push+pop at Count=1 across several pointer wraps.
    drive(1'b1, 32'h10000000, 32'h100, 1'b1, 1'b0);
    step();
    chk_state("pp0", 1'b1, 1'b1, 2'd1);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h10000000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      step();
      chk_state($sformatf("pp%0d", i), 1'b1, 1'b1, 2'd1);
      chk_head($sformatf("pp%0d", i), 32'h10000000 + 32'(i), 32'h100 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk_state("pp_drain", 1'b0, 1'b1, 2'd0);

    // Flush with a full buffer while fetch keeps offering.
    drive(1'b1, 32'hAAAA0001, 32'h180, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hAAAA0002, 32'h184, 1'b0, 1'b0);
    step();
    chk_state("pre_flush", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 32'hBBBB0003, 32'h188, 1'b1, 1'b1);
    step();
    chk_state("flush_full", 1'b0, 1'b1, 2'd0);
    drive(1'b1, 32'h08000010, 32'h200, 1'b0, 1'b0);
    step();
    chk_state("post_flush", 1'b1, 1'b1, 2'd1);
    chk_head("post_flush", 32'h08000010, 32'h200);

    // Flush must discard a push that would otherwise be accepted.
    drive(1'b1, 32'hDEAD0000, 32'h204, 1'b1, 1'b1);
    step();
    chk_state("flush_push", 1'b0, 1'b1, 2'd0);
    drive(1'b1, 32'h12345678, 32'h208, 1'b0, 1'b0);
    step();
    chk_state("after_flush_push", 1'b1, 1'b1, 2'd1);
    chk_head("after_flush_push", 32'h12345678, 32'h208);

    // Asynchronous reset mid-stream, sampled before any further edge.
    drive(1'b1, 32'hCAFE0001, 32'h20C, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 1'b1, 2'd0);
    chk_head("async_reset", 32'h0, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;

`ifdef IF_ID_STALL_STATS_EN
    drive(1'b1, 32'h00005555, 32'h300, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("stall_first", 64'(StallCycles), 64'd0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", 64'(StallCycles), 64'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("stall_flush", 64'(StallCycles), 64'd0);
    drive(1'b1, 32'h00006666, 32'h304, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    chk("stall_sat", 64'(StallCycles), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
